// File: rtl/peak_finder.sv
// Coarse-peak producer: scans the histogram RAM once per start request and
// publishes the index/count of the highest bin with a one-cycle peakReady strobe.
module peak_finder #(
    parameter int NB = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] min_count,
    output logic          hist_rd_en,
    output logic [NB-1:0] hist_rd_addr,
    input  logic [CW-1:0] hist_rd_data,
    output logic          busy,
    output logic          peakReady,
    output logic [NB-1:0] peakCH,
    output logic [CW-1:0] peakCount,
    output logic          peakFound
);

    // state | meaning
    // IDLE  | waiting for start
    // SCAN  | issuing one histogram read per cycle, addresses 0..N-1
    // FLUSH | no read; compares the datum returned for bin N-1
    // DONE  | result registers valid, peakReady high for this cycle
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    localparam int N = 1 << NB;
    localparam logic [NB-1:0] LAST_ADDR = NB'(N - 1);

    state_t        state_q, state_d;
    logic [NB-1:0] addr_q, addr_d;
    logic [NB-1:0] rd_idx_q;
    logic          rd_vld_q;
    logic [CW-1:0] max_q, max_d;
    logic [NB-1:0] max_idx_q, max_idx_d;
    logic [CW-1:0] min_q, min_d;
    logic [NB-1:0] peak_ch_q, peak_ch_d;
    logic [CW-1:0] peak_cnt_q, peak_cnt_d;
    logic          found_q, found_d;
    logic [CW-1:0] cand_max;
    logic [NB-1:0] cand_idx;

    // Strict greater-than keeps the lowest index on ties and ignores zero counts.
    always_comb begin
        cand_max = max_q;
        cand_idx = max_idx_q;
        if (rd_vld_q && (hist_rd_data > max_q)) begin
            cand_max = hist_rd_data;
            cand_idx = rd_idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        min_d      = min_q;
        peak_ch_d  = peak_ch_q;
        peak_cnt_d = peak_cnt_q;
        found_d    = found_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    addr_d    = '0;
                    min_d     = min_count;
                    max_d     = '0;
                    max_idx_d = '0;
                end
            end
            SCAN: begin
                max_d     = cand_max;
                max_idx_d = cand_idx;
                if (addr_q == LAST_ADDR) begin
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d    = DONE;
                max_d      = cand_max;
                max_idx_d  = cand_idx;
                peak_ch_d  = cand_idx;
                peak_cnt_d = cand_max;
                found_d    = (cand_max >= min_q);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_idx_q   <= '0;
            rd_vld_q   <= 1'b0;
            max_q      <= '0;
            max_idx_q  <= '0;
            min_q      <= '0;
            peak_ch_q  <= '0;
            peak_cnt_q <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_idx_q   <= addr_q;
            rd_vld_q   <= (state_q == SCAN);
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            min_q      <= min_d;
            peak_ch_q  <= peak_ch_d;
            peak_cnt_q <= peak_cnt_d;
            found_q    <= found_d;
        end
    end

    assign hist_rd_en   = (state_q == SCAN);
    assign hist_rd_addr = addr_q;
    assign busy         = (state_q == SCAN) || (state_q == FLUSH);
    assign peakReady    = (state_q == DONE);
    assign peakCH       = peak_ch_q;
    assign peakCount    = peak_cnt_q;
    assign peakFound    = found_q;

endmodule
